uart_rx_fifo: RTL

//  Receive buffer between the UART receiver and the CPU/MMIO read port. Captures

---
 rtl/uart_rx_fifo.sv | 106 ++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and the bus read port. The oldest byte
// falls through to o_Data; overflow is sticky and o_Irq signals fill level or idle timeout.
module uart_rx_fifo #(
  parameter int ADDR_W         = 4,
  parameter int IRQ_LEVEL      = 8,
  parameter int TIMEOUT_CYCLES = 17360,
  parameter int TO_W           = 15
) (
  input  logic              i_Clock,
  input  logic              reset,
  input  logic              i_Rx_DV,
  input  logic [7:0]        i_Rx_Byte,
  input  logic              i_Rd,
  input  logic              i_Clr_Ovf,
  output logic [7:0]        o_Data,
  output logic              o_Empty,
  output logic              o_Full,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  output logic              o_Irq
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C     = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] IRQ_LEVEL_C = (ADDR_W + 1)'(IRQ_LEVEL);
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic [TO_W-1:0]   to_cnt;
  logic              to_flag;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic drop;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a byte.
  always_comb begin
    empty = (count == '0);
    full  = (count == DEPTH_C);
    pop   = i_Rd & ~empty;
    push  = i_Rx_DV & (~full | pop);
    drop  = i_Rx_DV & full & ~pop;
  end

  // Storage is deliberately not reset; only the pointers and count are.
  always_ff @(posedge i_Clock) begin
    if (!reset && push) begin
      mem[wr_ptr] <= i_Rx_Byte;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      to_cnt   <= '0;
      to_flag  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      // A drop in the same cycle as a clear request wins so no loss goes unseen.
      if (drop) begin
        overflow <= 1'b1;
      end else if (i_Clr_Ovf) begin
        overflow <= 1'b0;
      end
      if (push || pop || empty) begin
        to_cnt  <= '0;
        to_flag <= 1'b0;
      end else if (!to_flag) begin
        if (to_cnt == TO_LAST) begin
          to_flag <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_Data     = empty ? 8'h00 : mem[rd_ptr];
    o_Empty    = empty;
    o_Full     = full;
    o_Count    = count;
    o_Overflow = overflow;
    o_Irq      = (count >= IRQ_LEVEL_C) | to_flag;
  end

endmodule
